conv_map_sequencer: RTL
=======================

Name: conv_map_sequencer

Overview:
Sequences the 5x5 convolution-point datapath across a full feature map, valid padding, stride 1.
- Walks every output coordinate in raster order.
- Presents each window origin to the window buffer that drives map_block.
- Samples the datapath result after a fixed latency.
- Streams results out over a valid/ready handshake with linear output address and end-of-map flag.
- Sits between the layer control FSM (start/done) and the output feature-map writer.

Parameters:
BITWIDTH, 16, width of conv_value and out_data
MAP_W, 28, input map width; legal 5..255
MAP_H, 28, input map height; legal 5..255
CONV_LAT, 1, cycles from win_valid to conv_value valid; legal 1..15
COORD_W, 8, width of window-origin coordinates
ADDR_W, 16, width of out_addr

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin one map pass; honoured only in IDLE
abort  in  1  cancel pass; return to IDLE, no done
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last output accepted
win_valid  out  1  one-cycle pulse: new window origin issued
win_row  out  COORD_W  window top-left row
win_col  out  COORD_W  window top-left column
conv_value  in  BITWIDTH  convolution-point result
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_data  out  BITWIDTH  registered result
out_addr  out  ADDR_W  row*OUT_W+col of the result
out_last  out  1  high with the final result of the map

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0; state IDLE; row, col, lat and addr counters 0.
- Derived sizes: OUT_W = MAP_W-4 and OUT_H = MAP_H-4. Total outputs = OUT_W*OUT_H (576 at defaults).
- FSM states: IDLE, ISSUE, WAIT, OUT, DONE.
- IDLE:
  - start=1 -> ISSUE.
  - Clear row, col and addr to 0.
- ISSUE (1 cycle):
  - win_valid=1 with current row/col.
  - Load lat counter = CONV_LAT.
  - -> WAIT.
- WAIT:
  - Decrement lat each cycle.
  - In the cycle lat==1, register conv_value into out_data -> OUT.
  - Timing: ISSUE at cycle t means the sample is taken at t+CONV_LAT.
- OUT:
  - out_valid=1.
  - out_data, out_addr and out_last are held stable until the handshake.
  - On out_valid&&out_ready:
    - out_last=1 -> DONE.
    - Otherwise advance and -> ISSUE. If col==OUT_W-1: col=0, row+1; else col+1. addr+1.
- DONE: done=1 for one cycle -> IDLE.
- win_row/win_col hold their value from ISSUE through OUT. The window buffer may rely on this stability.
- out_last = (row==OUT_H-1)&&(col==OUT_W-1). Valid only while out_valid.
- Throughput with out_ready tied high: 2+CONV_LAT cycles per output (3 at default).
  - Full pass latency from start to done = OUT_W*OUT_H*(2+CONV_LAT)+1 cycles.
- out_ready low stalls OUT indefinitely. No result is dropped or duplicated.
- out_ready high outside OUT has no effect.
- start while busy: ignored.
- start in the DONE cycle: ignored. A new pass requires start in IDLE.
- abort (any state except IDLE):
  - Next state IDLE.
  - out_valid, win_valid and busy drop the next cycle.
  - done is not pulsed. Counters are cleared.
- Simultaneous abort and the out_valid&&out_ready handshake: abort wins. The transfer counts as accepted by downstream, but done is not pulsed.
- rst mid-pass: same effect as abort, plus out_data and out_addr are cleared to 0.
- conv_value is sampled only in the last WAIT cycle. It is ignored at all other times.
- No arithmetic on data. out_data is a bit-exact copy of conv_value.

Test Plan:
1. MAP_W=7, MAP_H=6, CONV_LAT=1, out_ready=1, conv_value = {win_row,win_col} echoed by the bench model, start pulse -> 6 outputs in this order:
   - (0,0) addr0, (0,1) addr1, (0,2) addr2, (1,0) addr3, (1,1) addr4, (1,2) addr5.
   - out_last only on addr5. done pulses 1 cycle after the last handshake.
   - Total 19 cycles from start to done.
2. Same configuration, out_ready held low for 4 cycles on addr2 -> out_valid, out_data and out_addr are stable for 4 cycles and win_col stays 2; transfer then completes; no gap or duplicate in addresses.
3. CONV_LAT=3 -> win_valid pulses spaced exactly 5 cycles apart with ready high; each sampled value equals conv_value at ISSUE+3.
4. abort asserted while in WAIT for addr3 -> IDLE next cycle, busy=0, no done. A following start restarts at addr0 with row=col=0.
5. rst asserted in OUT with out_valid=1 -> next cycle: all outputs 0, state IDLE. start issued during busy in test 1 has no effect on sequence or count.
6. Defaults (28x28) with random out_ready backpressure -> exactly 576 accepted transfers, addresses 0..575 in order, out_last only on 575, one done pulse.

Source files
------------

// File: rtl/conv_map_sequencer.sv
// conv_map_sequencer: walks every valid-padding, stride-1 window origin of a
// MAP_H x MAP_W feature map in raster order. For each origin it issues the
// coordinates to the window buffer and samples the convolution-point result
// after CONV_LAT cycles. The result is then offered downstream with its linear
// output address and an end-of-map flag.
//
// Handshake: a result transfers on a rising clk edge where out_valid and
// out_ready are both high. out_valid is only raised in OUT, and out_data,
// out_addr and out_last stay frozen until that transfer. out_ready has no
// effect at any other time.
module conv_map_sequencer #(
   parameter int BITWIDTH = 16,
   parameter int MAP_W    = 28,
   parameter int MAP_H    = 28,
   parameter int CONV_LAT = 1,
   parameter int COORD_W  = 8,
   parameter int ADDR_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                win_valid,
   output logic [COORD_W-1:0]  win_row,
   output logic [COORD_W-1:0]  win_col,
   input  logic [BITWIDTH-1:0] conv_value,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITWIDTH-1:0] out_data,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_last,
   output logic [2:0]          dbg_state
);

   // Last valid window origin: OUT_W-1 = MAP_W-5, OUT_H-1 = MAP_H-5.
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(MAP_W - 5);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(MAP_H - 5);
   localparam logic [3:0]         LAT_LOAD = 4'(CONV_LAT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_OUT   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [COORD_W-1:0]    row;
   logic [COORD_W-1:0]    col;
   logic [ADDR_W-1:0]     addr;
   logic [3:0]            lat;
   logic                  at_last;
   logic                  sample;
   logic                  xfer;
   logic                  cancel;

   assign at_last   = (row == LAST_ROW) && (col == LAST_COL);
   // abort is meaningless while idle, so it only cancels an active pass
   assign cancel    = abort && (state != S_IDLE);

   assign win_row   = row;
   assign win_col   = col;
   assign out_addr  = addr;
   assign out_last  = out_valid && at_last;
   assign dbg_state = state;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and per-state strobes
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      win_valid = 1'b0;
      out_valid = 1'b0;
      sample    = 1'b0;
      xfer      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            win_valid = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (lat == 4'd1) begin
               sample    = 1'b1;
               state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               xfer      = 1'b1;
               state_nxt = at_last ? S_DONE : S_ISSUE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // abort beats any concurrent handshake; the pass simply ends
      if (cancel) state_nxt = S_IDLE;
   end

   // Coordinate, address, latency counters and the result register
   always_ff @(posedge clk) begin
      if (rst) begin
         row      <= '0;
         col      <= '0;
         addr     <= '0;
         lat      <= '0;
         out_data <= '0;
      end else if (cancel) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
         lat  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               row  <= '0;
               col  <= '0;
               addr <= '0;
            end
            S_ISSUE: lat <= LAT_LOAD;
            S_WAIT: begin
               lat <= lat - 4'd1;
               if (sample) out_data <= conv_value;
            end
            S_OUT: begin
               if (xfer && !at_last) begin
                  addr <= addr + ADDR_W'(1);
                  if (col == LAST_COL) begin
                     col <= '0;
                     row <= row + COORD_W'(1);
                  end else begin
                     col <= col + COORD_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
